// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus.
// master = stream source / memory side, slave = the loader.
interface imem_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed byte stream into
// instruction memory and holds the core in reset until the load checks out.
// Ports: clk, rst (sync, active-high), start (begin load),
//   bus (slave): byte_in/byte_valid/byte_ready in, imem_we/addr/wdata out,
//   core_rst/done/err status, words_loaded = words written this load.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         core_rst,
    output logic         done,
    output logic         err,
    output logic [15:0]  words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] LP_DEPTH = 17'(DEPTH_WORDS);

    state_t      r_state;
    state_t      w_next;

    logic        r_byte_ready;
    logic        r_we;
    logic        r_core_rst;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [15:0] r_len;
    logic [15:0] r_words;
    logic [7:0]  r_csum;
    logic [1:0]  r_cnt;

    logic        w_fire;
    logic        w_start_ok;
    logic        w_enter_write;
    logic [15:0] w_len_full;
    logic [15:0] w_words_inc;
    logic [31:0] w_word_shift;
    logic [31:0] w_addr_calc;

    assign w_fire       = r_byte_ready & bus.byte_valid;
    assign w_start_ok   = start & ((r_state == S_IDLE) |
                                   (r_state == S_DONE) |
                                   (r_state == S_ERR));
    assign w_enter_write = (r_state == S_DATA) & (w_next == S_WRITE);
    assign w_len_full   = {bus.byte_in, r_len[7:0]};
    assign w_words_inc  = r_words + 16'd1;
    // Little-endian assembly: shift right so the first byte ends in [7:0].
    assign w_word_shift = {bus.byte_in, r_word[31:8]};
    assign w_addr_calc  = BASE_ADDR + {14'd0, r_words, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_next = S_LEN0;
                end
            end
            S_LEN0: begin
                if (w_fire) begin
                    w_next = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_fire) begin
                    if (w_len_full == 16'd0) begin
                        w_next = S_CSUM;
                    end else if ({1'b0, w_len_full} > LP_DEPTH) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_fire && (r_cnt == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next = (w_words_inc == r_len) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (w_fire) begin
                    w_next = (bus.byte_in == r_csum) ? S_DONE : S_ERR;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Status and bus outputs are registered from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
        end else begin
            r_byte_ready <= (w_next == S_LEN0) | (w_next == S_LEN1) |
                            (w_next == S_DATA) | (w_next == S_CSUM);
            r_we         <= (w_next == S_WRITE);
            r_core_rst   <= (w_next != S_DONE);
            r_done       <= (w_next == S_DONE);
            r_err        <= (w_next == S_ERR);
            if (w_enter_write) begin
                r_addr  <= w_addr_calc;
                r_wdata <= w_word_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= 32'd0;
            r_len   <= 16'd0;
            r_words <= 16'd0;
            r_csum  <= 8'd0;
            r_cnt   <= 2'd0;
        end else if (w_start_ok) begin
            r_word  <= 32'd0;
            r_len   <= 16'd0;
            r_words <= 16'd0;
            r_csum  <= 8'd0;
            r_cnt   <= 2'd0;
        end else begin
            case (r_state)
                S_LEN0: begin
                    if (w_fire) begin
                        r_len[7:0] <= bus.byte_in;
                    end
                end
                S_LEN1: begin
                    if (w_fire) begin
                        r_len[15:8] <= bus.byte_in;
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        r_word <= w_word_shift;
                        r_csum <= r_csum ^ bus.byte_in;
                        r_cnt  <= r_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_words <= w_words_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign core_rst       = r_core_rst;
    assign done           = r_done;
    assign err            = r_err;
    assign words_loaded   = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams against a stream-level model of the
// loader; a negedge monitor checks every write and status every cycle.
module tb_imem_loader;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        core_rst;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    imem_loader_if bus();

    imem_loader #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .core_rst    (core_rst),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [7:0]  consumed[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.byte_valid && bus.byte_ready)
                consumed.push_back(bus.byte_in);
            chk("core_rst_vs_done", 32'(core_rst), 32'(!done));
            chk("done_err_excl", 32'(done & err), 32'd0);
            if (bus.imem_we) begin
                log_addr.push_back(bus.imem_addr);
                log_data.push_back(bus.imem_wdata);
                chk("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
                if (exp_addr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %h data %h want none",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    chk("waddr", bus.imem_addr, exp_addr.pop_front());
                    chk("wdata", bus.imem_wdata, exp_data.pop_front());
                end
            end
        end
    end

    // Stream-level model: parse the byte list and derive writes and outcome.
    task automatic model(input logic [7:0] s[$], output int n_cons,
                         output bit exp_done, output int exp_words);
        int n;
        logic [7:0] cs;
        n = int'(s[0]) | (int'(s[1]) << 8);
        exp_addr.delete();
        exp_data.delete();
        if (n > DEPTH) begin
            n_cons    = 2;
            exp_done  = 1'b0;
            exp_words = 0;
            return;
        end
        cs = 8'd0;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back({s[5+4*i], s[4+4*i], s[3+4*i], s[2+4*i]});
            for (int k = 0; k < 4; k++) cs ^= s[2+4*i+k];
        end
        n_cons    = 3 + 4 * n;
        exp_done  = (s[2+4*n] == cs);
        exp_words = n;
    endtask

    task automatic idle(int k);
        bus.byte_valid = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present a byte and hold it until the loader takes it.
    task automatic push(logic [7:0] b);
        int n;
        n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.byte_ready) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL push_timeout: got no ready want ready for %h", b);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(string nm, input logic [7:0] s[$], int gap);
        int  n_cons;
        bit  exp_done;
        int  exp_words;
        int  mism;
        model(s, n_cons, exp_done, exp_words);
        consumed.delete();
        log_addr.delete();
        log_data.delete();
        pulse_start();
        for (int i = 0; i < n_cons; i++) begin
            push(s[i]);
            if (gap > 0) idle(gap);
        end
        idle(3);
        @(negedge clk);
        chk({nm, "_done"}, 32'(done), 32'(exp_done));
        chk({nm, "_err"}, 32'(err), 32'(!exp_done));
        chk({nm, "_core_rst"}, 32'(core_rst), 32'(!exp_done));
        chk({nm, "_words"}, 32'(words_loaded), 32'(exp_words));
        chk({nm, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
        chk({nm, "_nbytes"}, 32'(consumed.size()), 32'(n_cons));
        mism = 0;
        for (int i = 0; i < n_cons; i++)
            if (i >= consumed.size() || consumed[i] !== s[i]) mism++;
        chk({nm, "_byte_order"}, 32'(mism), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] s[$];
        rst            = 1'b1;
        start          = 1'b0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        s = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        run_load("two_word_ok", s, 0);
        chk("lit_nwrites", 32'(log_addr.size()), 32'd2);
        chk("lit_a0", log_addr[0], 32'h0000_0000);
        chk("lit_d0", log_data[0], 32'h0010_0513);
        chk("lit_a1", log_addr[1], 32'h0000_0004);
        chk("lit_d1", log_data[1], 32'h0020_0593);
        chk("lit_words", 32'(words_loaded), 32'd2);
        chk("lit_done", 32'(done), 32'd1);

        s[10] = 8'h81;
        run_load("bad_csum", s, 0);
        chk("lit_bad_nwrites", 32'(log_addr.size()), 32'd2);
        chk("lit_bad_err", 32'(err), 32'd1);

        s = {8'h41, 8'h00};
        run_load("too_long", s, 0);
        chk("lit_long_nwrites", 32'(log_addr.size()), 32'd0);
        chk("lit_long_err", 32'(err), 32'd1);

        s = {8'h00, 8'h00, 8'h00};
        run_load("zero_len", s, 0);
        chk("lit_zero_nwrites", 32'(log_addr.size()), 32'd0);
        chk("lit_zero_done", 32'(done), 32'd1);

        s = {8'h03, 8'h00};
        for (int i = 1; i <= 12; i++) s.push_back(8'(i));
        s.push_back(8'h0C);
        run_load("three_word_stream", s, 0);
        chk("lit_three_nwrites", 32'(log_addr.size()), 32'd3);
        chk("lit_three_d2", log_data[2], 32'h0C0B_0A09);

        s = {8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
             8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
        run_load("gappy", s, 4);
        chk("lit_gappy_d0", log_data[0], 32'hEFBE_ADDE);

        s = {8'h40, 8'h00};
        for (int i = 0; i < 256; i++) s.push_back(8'($urandom_range(0, 255)));
        begin
            logic [7:0] x;
            x = 8'd0;
            for (int i = 2; i < 258; i++) x ^= s[i];
            s.push_back(x);
        end
        run_load("full_depth", s, 0);
        chk("lit_full_nwrites", 32'(log_addr.size()), 32'd64);
        chk("lit_full_last_addr", log_addr[63], 32'h0000_00FC);

        exp_addr.delete();
        exp_data.delete();
        pulse_start();
        push(8'h01);
        push(8'h00);
        push(8'hAA);
        push(8'hBB);
        bus.byte_valid = 1'b0;
        rst            = 1'b1;
        start          = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(bus.byte_ready), 32'd0);
        chk("midrst_core_rst", 32'(core_rst), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_words", 32'(words_loaded), 32'd0);
        chk("midrst_addr", bus.imem_addr, 32'd0);
        chk("midrst_wdata", bus.imem_wdata, 32'd0);
        @(posedge clk);
        #1;
        s = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        run_load("after_rst", s, 0);
        chk("lit_rst_nwrites", 32'(log_addr.size()), 32'd1);
        chk("lit_rst_a0", log_addr[0], BASE);
        chk("lit_rst_d0", log_data[0], 32'h4433_2211);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
